// File: rtl/decomp_pkg.sv
// ---------------------------------------------------------------------------
// decomp_pkg
// Shared constants for the burst decompression expander: the default bus
// geometry and the FSM state encodings (IDLE / RAW / HDR / EXP).
// ---------------------------------------------------------------------------
package decomp_pkg;

    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned BURST_LEN_DEF = 4;

    // FSM state type and encodings
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RAW  = 2'd1;
    localparam state_t ST_HDR  = 2'd2;
    localparam state_t ST_EXP  = 2'd3;

endpackage : decomp_pkg

// File: rtl/decomp_expander_if.sv
// ---------------------------------------------------------------------------
// decomp_expander_if
// Bundles the three streams around the expander:
//   s_*    : input beats from the memory-controller R stream
//   flag*  : comp_flag FIFO head (flag_ready is the pop strobe)
//   m_*    : output beats towards the interconnect R stream
// Modports:
//   slave  : the expander side (consumes s_*/flag*, produces m_*)
//   master : the environment side (memory controller, flag FIFO, sink)
// ---------------------------------------------------------------------------
interface decomp_expander_if #(
    parameter int unsigned DATA_W = 64
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    logic              flag_valid;
    logic              flag;
    logic              flag_ready;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sop;
    logic              m_eop;

    modport slave (
        input  s_valid, s_data, s_last,
        input  flag_valid, flag,
        input  m_ready,
        output s_ready, flag_ready,
        output m_valid, m_data, m_sop, m_eop
    );

    modport master (
        output s_valid, s_data, s_last,
        output flag_valid, flag,
        output m_ready,
        input  s_ready, flag_ready,
        input  m_valid, m_data, m_sop, m_eop
    );

endinterface : decomp_expander_if

// File: rtl/decomp_out_reg.sv
// ---------------------------------------------------------------------------
// decomp_out_reg
// Single-entry valid/ready pipeline stage. Loads whenever it is empty or
// its content is leaving this cycle, so it sustains one beat per cycle and
// hands off / reloads in the same cycle. Payload is held while stalled.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   in_valid_i    : upstream has a payload to load
//   in_ready_o    : stage can load this cycle (combinational)
//   in_data_i     : payload to load
//   out_valid_o   : registered valid
//   out_ready_i   : downstream accepts
//   out_data_o    : registered payload
// ---------------------------------------------------------------------------
module decomp_out_reg
    import decomp_pkg::*;
#(
    parameter int unsigned W = DATA_W_DEF + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Storage: payload only changes on a load, so it is stable under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule : decomp_out_reg

// File: rtl/decomp_expander.sv
// ---------------------------------------------------------------------------
// decomp_expander
// Re-expands masked-compressed read bursts. For every burst a comp_flag is
// popped: flag=0 passes the burst through unchanged; flag=1 reads a header
// beat whose low BURST_LEN bits are a beat mask, then emits BURST_LEN beats,
// taking an input beat for each set mask bit and inserting an all-zero beat
// for each clear bit. Outputs go through a one-entry register stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : decomp_expander_if.slave (s_*, flag*, m_* streams)
//   err_o      : sticky protocol error (s_last misplaced or missing)
// Build option:
//   DECOMP_ERR_CHK_EN defined  -> s_last placement checking drives err_o
//   DECOMP_ERR_CHK_EN undefined -> err_o tied low, no checking logic
// ---------------------------------------------------------------------------
module decomp_expander
    import decomp_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decomp_expander_if.slave       bus,
    output logic                   err_o
);

    localparam int unsigned IDX_W    = $clog2(BURST_LEN);
    localparam int unsigned PAY_W    = DATA_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       i_q, i_d;
    logic [BURST_LEN-1:0]   mask_q, mask_d;
    logic                   first_q, first_d;

    logic                   s_ready_c;
    logic                   flag_ready_c;
    logic                   ld_valid_c;
    logic                   ld_ready_c;
    logic [PAY_W-1:0]       ld_pay_c;
    logic [PAY_W-1:0]       out_pay;
    logic                   mask_bit_c;

    assign mask_bit_c = mask_q[i_q];

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            mask_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            mask_q  <= mask_d;
            first_q <= first_d;
        end
    end

    // Next state, handshakes and output-register load
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        mask_d       = mask_q;
        first_d      = first_q;
        s_ready_c    = 1'b0;
        flag_ready_c = 1'b0;
        ld_valid_c   = 1'b0;
        ld_pay_c     = '0;

        case (state_q)
            ST_IDLE: begin
                flag_ready_c = bus.flag_valid;
                if (bus.flag_valid) begin
                    state_d = bus.flag ? ST_HDR : ST_RAW;
                    first_d = 1'b1;
                    i_d     = '0;
                end
            end

            ST_RAW: begin
                s_ready_c  = ld_ready_c;
                ld_valid_c = bus.s_valid;
                ld_pay_c   = {first_q, bus.s_last, bus.s_data};
                if (bus.s_valid && ld_ready_c) begin
                    first_d = 1'b0;
                    // Saturating beat count, only used to spot overlong bursts
                    if (i_q != LAST_IDX) begin
                        i_d = i_q + IDX_W'(1);
                    end
                    if (bus.s_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HDR: begin
                // Header never reaches the output, so it needs no slot
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    mask_d  = bus.s_data[BURST_LEN-1:0];
                    i_d     = '0;
                    state_d = ST_EXP;
                end
            end

            ST_EXP: begin
                // Clear mask bit: zero beat is always available, no input taken
                s_ready_c  = mask_bit_c && ld_ready_c;
                ld_valid_c = mask_bit_c ? bus.s_valid : 1'b1;
                ld_pay_c   = {(i_q == '0), (i_q == LAST_IDX),
                              (mask_bit_c ? bus.s_data : DATA_W'(0))};
                if (ld_valid_c && ld_ready_c) begin
                    if (i_q == LAST_IDX) begin
                        i_d     = '0;
                        state_d = ST_IDLE;
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // No handshakes towards upstream while held in reset
        if (!rst_n) begin
            s_ready_c    = 1'b0;
            flag_ready_c = 1'b0;
            ld_valid_c   = 1'b0;
        end
    end

    assign bus.s_ready    = s_ready_c;
    assign bus.flag_ready = flag_ready_c;

    // Output register stage: {sop, eop, data}
    decomp_out_reg #(
        .W (PAY_W)
    ) u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (ld_valid_c),
        .in_ready_o  (ld_ready_c),
        .in_data_i   (ld_pay_c),
        .out_valid_o (bus.m_valid),
        .out_ready_i (bus.m_ready),
        .out_data_o  (out_pay)
    );

    assign bus.m_sop  = out_pay[PAY_W-1];
    assign bus.m_eop  = out_pay[PAY_W-2];
    assign bus.m_data = out_pay[DATA_W-1:0];

`ifdef DECOMP_ERR_CHK_EN
    logic err_q;
    logic err_set_c;
    logic exp_is_last_c;

    // Current mask bit is the highest set one -> this beat must carry s_last
    assign exp_is_last_c = ((mask_q >> i_q) >> 1) == '0;

    // s_last placement check on every accepted input beat
    always_comb begin
        err_set_c = 1'b0;
        if (bus.s_valid && s_ready_c) begin
            case (state_q)
                ST_RAW: err_set_c = (i_q == LAST_IDX) && !bus.s_last;
                ST_HDR: err_set_c = bus.s_last != (bus.s_data[BURST_LEN-1:0] == '0);
                ST_EXP: err_set_c = bus.s_last != exp_is_last_c;
                default: err_set_c = 1'b0;
            endcase
        end
    end

    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set_c) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule : decomp_expander
